out_port_fifo: RTL

Output-port stage downstream of the CPU's OUT instruction path. It captures each byte the sequencer writes to the output port into a small FIFO, then presents the bytes to an external consumer over a valid/ready handshake. It also holds the last written value for a static display. When the FIFO fills, it raises a stall request that the sequencer uses to gate the CPU clock, so the CPU is never forced to drop an OUT.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/out_port_fifo.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants.
//
// WORD_W : width of the CPU data bus. Blocks that carry bus bytes use it as
//          their default data width.
package cpu_pkg;

    localparam int WORD_W = 8;

endpackage : cpu_pkg

// File: rtl/out_port_fifo.sv
// Output-port FIFO behind the CPU's OUT instruction.
//
// Bytes written by the sequencer are queued and handed to an external
// consumer over a valid/ready handshake. The most recently accepted byte is
// held for a static display. When the queue is full, stall_req asks the
// sequencer to gate the CPU clock, so the CPU never has to drop an OUT.
//
// Ports
//   clk        : system clock, rising edge
//   clr        : synchronous active-high reset
//   wr_en      : write strobe from the CPU (inverse of low_ld_out_reg)
//   wr_data    : byte from the CPU bus
//   out_data   : head-of-queue byte, meaningful only while out_valid = 1
//   out_valid  : queue holds at least one byte
//   out_ready  : consumer takes out_data this cycle
//   last_value : last accepted byte
//   count      : current occupancy
//   full       : count == DEPTH
//   empty      : count == 0
//   stall_req  : same as full; the sequencer gates the CPU clock with it
//   overflow   : sticky, set when a write had to be dropped
module out_port_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,       // power of 2, at least 2
    parameter int WIDTH = WORD_W
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           last_value,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       stall_req,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             overflow_q, overflow_d;

    logic is_full;
    logic is_empty;
    logic pop;
    logic push;

    // Flags come from the count register alone, so they are glitch-free and
    // full/empty stay distinct even though both pointers are only log2(DEPTH)
    // bits wide.
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // out_ready is ignored while nothing is queued. A push into a full queue
    // is still accepted when a pop frees the head slot on the same edge.
    assign pop  = !is_empty && out_ready;
    assign push = wr_en && (!is_full || pop);

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so each path defines every signal and no latch appears.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of 2, so natural wrap is the modulo.
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            last_d          = wr_data;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Write while full with no pop to free a slot: the byte is lost.
        if (wr_en && !push) begin
            overflow_d = 1'b1;
        end
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage has no reset. Stale entries are never visible because
    // out_valid is derived from count, and a reset-free array can map onto
    // plain RAM or distributed memory.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Combinational read at the head; no output register stage.
    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = !is_empty;
    assign empty      = is_empty;
    assign full       = is_full;
    assign stall_req  = is_full;
    assign count      = count_q;
    assign last_value = last_q;
    assign overflow   = overflow_q;

endmodule : out_port_fifo
